// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
//   tx_state_t : transmitter FSM state encoding
//   calc_div() : rounded clock cycles per bit for a given clock and line rate
// Optional feature macro: UART_TX_PARITY_EN adds the StParity state.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } tx_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  // Board defaults: 100 MHz clock, 115200 baud.
  localparam int unsigned DefDiv  = calc_div(100_000_000, 115_200);
  localparam int unsigned DefCntW = $clog2(DefDiv);

endpackage

// File: rtl/uart_tx.sv
// UART transmitter core: baud counter, frame FSM and shift register.
// A one-cycle start_i pulse in idle latches data_i and sends one frame, LSB first.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit before stop.
// Ports:
//   clk_i    in   system clock, rising edge
//   reset_n  in   asynchronous reset, active-high
//   start_i  in   one-cycle frame request, ignored while busy
//   data_i   in   payload, sampled on the accepted start
//   tx_o     out  registered serial line, idle high
//   busy_o   out  registered, high while a frame is in progress
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int unsigned Div  = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned BitW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(DATA_BITS - 1);

  tx_state_t              state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   tick;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  assign tick = (cnt_q == CntMax);

  // State register
  always_ff @(posedge clk_i or posedge reset_n) begin
    if (reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    // Baud counter free-runs 0..Div-1 whenever a frame is in progress.
    if (state_q != StIdle) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StStart;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = data_i;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data_i;
`endif
        end
      end
      StStart: begin
        if (tick) state_d = StData;
      end
      StData: begin
        if (tick) begin
          if (bit_q == BitMax) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) state_d = StStop;
      end
`endif
      StStop: begin
        if (tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registers change on the
  // same edge as the FSM, with no combinational path to the pins.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    unique case (state_d)
      StIdle:   busy_d = 1'b0;
      StStart:  tx_d   = 1'b0;
      StData:   tx_d   = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d   = par_q;
`endif
      StStop:   tx_d   = 1'b1;
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/uart_tx_top.sv
// Board-level UART transmitter: each rising edge of the asynchronous send_i
// request transmits data_i as one serial frame on tx_o.
// Optional feature macro: UART_TX_PARITY_EN enables an even-parity bit.
// Ports:
//   clk_i    in   100 MHz board clock, rising edge
//   reset_n  in   asynchronous reset, active-high
//   send_i   in   asynchronous push-button request, rising edge starts a frame
//   data_i   in   payload from switches
//   tx_o     out  serial line to USB-UART bridge, idle high
//   busy_o   out  high while a frame is in progress
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n,
  input  logic                 send_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 tx_o,
  output logic                 busy_o
);

  // [0],[1]: two-flop synchronizer; [2]: previous synchronized value for edge detect.
  logic [2:0] sync_q, sync_d;
  logic       start;

  assign sync_d = {sync_q[1:0], send_i};

  always_ff @(posedge clk_i or posedge reset_n) begin
    if (reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign start = sync_q[1] & ~sync_q[2];

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS)
  ) u_uart_tx (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .start_i (start),
    .data_i  (data_i),
    .tx_o    (tx_o),
    .busy_o  (busy_o)
  );

endmodule

// File: tb/tb_uart_tx_top.sv
module tb_uart_tx_top;

  localparam int Div = 868;
`ifdef UART_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif
  localparam int Frame = NBits * Div;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_top #(
    .CLK_FREQ  (100_000_000),
    .BAUD      (115_200),
    .DATA_BITS (8)
  ) dut (
    .clk_i   (clk),
    .reset_n (reset_n),
    .send_i  (send),
    .data_i  (data),
    .tx_o    (tx),
    .busy_o  (busy)
  );

  // Watch the line for n cycles: must stay idle.
  task automatic idle_check(input int n, input string name);
    int bad = 0;
    logic btx = 1'b1;
    logic bbusy = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) begin
        bad++;
        btx = tx;
        bbusy = busy;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s idle: tx=%b busy=%b in %0d of %0d cycles, expected tx=1 busy=0",
               name, btx, bbusy, bad, n);
    end
  endtask

  // Send (or continue) one frame and check it cycle by cycle against the ideal
  // bit sequence. t counts falling edges after send rises; frame cycle c is
  // sampled at t = c + 3.
  task automatic run_frame(input logic [7:0] d, input int send_len, input int pulse_at,
                           input logic chained, input logic chain_next,
                           input logic [7:0] next_d, input string name);
    logic exp_bits[NBits];
    int   bad[NBits];
    logic badv[NBits];
    int   busy_bad = 0;
    int   pre_bad = 0;
    int   t;
    int   b;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
    exp_bits[9] = ^d;
`endif
    exp_bits[NBits - 1] = 1'b1;
    for (int i = 0; i < NBits; i++) begin
      bad[i] = 0;
      badv[i] = 1'bx;
    end
    if (!chained) begin
      @(negedge clk);
      data = d;
      send = 1'b1;
      t = 0;
    end else begin
      t = 2;
    end
    while (t < Frame + 3) begin
      @(negedge clk);
      t++;
      if (t == send_len) send = 1'b0;
      if (pulse_at > 0 && t == pulse_at) send = 1'b1;
      if (pulse_at > 0 && t == pulse_at + 3) send = 1'b0;
      if (t == 10) data = ~d;
      if (chain_next && t == Frame + 1) begin
        send = 1'b1;
        data = next_d;
      end
      if (t < 3) begin
        if (tx !== 1'b1 || busy !== 1'b0) pre_bad++;
      end else if (t < Frame + 3) begin
        b = (t - 3) / Div;
        if (tx !== exp_bits[b]) begin
          bad[b]++;
          badv[b] = tx;
        end
        if (busy !== 1'b1) busy_bad++;
      end else begin
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s end: tx=%b busy=%b, expected tx=1 busy=0", name, tx, busy);
        end
      end
    end
    if (!chained) begin
      checks++;
      if (pre_bad != 0) begin
        errors++;
        $display("FAIL %s latency: line active in %0d of 2 cycles before start edge, expected 0",
                 name, pre_bad);
      end
    end
    for (int i = 0; i < NBits; i++) begin
      checks++;
      if (bad[i] != 0) begin
        errors++;
        $display("FAIL %s bit %0d: tx=%b in %0d of %0d cycles, expected %b",
                 name, i, badv[i], bad[i], Div, exp_bits[i]);
      end
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy: low in %0d of %0d frame cycles, expected 0",
               name, busy_bad, Frame);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
    end
    reset_n = 1'b0;
    idle_check(50, "after_reset");
  endtask

  task automatic test_pattern_55;
    run_frame(8'h55, 3, 0, 1'b0, 1'b0, 8'h00, "data55");
  endtask

  task automatic test_zeros_ones;
    run_frame(8'h00, 3, 0, 1'b0, 1'b0, 8'h00, "data00");
    run_frame(8'hFF, 3, 0, 1'b0, 1'b0, 8'h00, "dataFF");
  endtask

  task automatic test_ignore_mid_frame;
    logic [7:0] d = 8'($urandom);
    run_frame(d, 3, 4000, 1'b0, 1'b0, 8'h00, "mid_pulse");
    idle_check(100, "mid_pulse");
  endtask

  task automatic test_held_send;
    logic [7:0] d = 8'($urandom);
    run_frame(d, 1 << 30, 0, 1'b0, 1'b0, 8'h00, "held");
    idle_check(20000 - Frame - 3, "held_high");
    send = 1'b0;
    idle_check(20, "held_release");
  endtask

  task automatic test_back_to_back;
`ifdef UART_TX_PARITY_EN
    logic [7:0] d1 = 8'h07;
    logic [7:0] d2 = 8'h03;
`else
    logic [7:0] d1 = 8'($urandom);
    logic [7:0] d2 = 8'($urandom);
`endif
    run_frame(d1, 3, 0, 1'b0, 1'b1, d2, "b2b_first");
    run_frame(d2, 3, 0, 1'b1, 1'b0, 8'h00, "b2b_second");
    idle_check(20, "b2b");
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    data = 8'($urandom);
    send = 1'b1;
    repeat (3) @(negedge clk);
    send = 1'b0;
    repeat (2999) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre: busy=%b, expected 1", busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid abort: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
    end
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    idle_check(6000, "reset_mid_after");
  endtask

  initial begin
    test_reset();
    test_pattern_55();
    test_zeros_ones();
    test_ignore_mid_frame();
    test_held_send();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
